// File: rtl/div_rate_detector_if.sv
// Signal bundle between a divided-clock source and the rate detector.
// The master side drives the clock under test and observes the measurement
// results. The slave side is the detector itself.
interface div_rate_detector_if #(
    parameter int unsigned CNT_W = 8
);
    logic             sig_in;   // divided clock under test, synchronous to clk
    logic [CNT_W-1:0] period;   // last measured period in clk cycles
    logic             valid;    // pulse: period/match updated this cycle
    logic             match;    // last period equals one of the divider periods
    logic [1:0]       sel_out;  // decoded divider select code
    logic             locked;   // stable rate detected
    logic             timeout;  // pulse: measurement aborted for lack of an edge

    modport master (
        output sig_in,
        input  period,
        input  valid,
        input  match,
        input  sel_out,
        input  locked,
        input  timeout
    );

    modport slave (
        input  sig_in,
        output period,
        output valid,
        output match,
        output sel_out,
        output locked,
        output timeout
    );
endinterface

// File: rtl/div_rate_detector.sv
// Divided-clock rate detector.
// Measures the number of clk cycles between rising edges of sig_in, decodes
// the period back to the 2-bit divider select code and asserts locked once
// LOCK_N consecutive measurements agree on the same code.
module div_rate_detector #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DIV0    = 2,
    parameter int unsigned DIV1    = 4,
    parameter int unsigned DIV2    = 8,
    parameter int unsigned DIV3    = 16,
    parameter int unsigned TIMEOUT = 255,  // must fit in CNT_W bits and exceed DIV3
    parameter int unsigned LOCK_N  = 2     // 1..15
) (
    input  logic                clk,
    input  logic                rst,
    div_rate_detector_if.slave  bus
);

    localparam logic [3:0] RunMax = 4'd15;

    typedef enum logic [0:0] {
        StIdle,
        StMeasure
    } state_e;

    state_e           state_q;
    logic             sig_q;        // sig_in delayed by one cycle
    logic [CNT_W-1:0] cnt_q;        // cycles since the last rising edge
    logic [3:0]       run_q;        // consecutive hits of last_code_q
    logic [1:0]       last_code_q;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             match_q;
    logic [1:0]       sel_q;
    logic             locked_q;
    logic             timeout_q;

    logic             rise;
    logic             hit;
    logic [1:0]       code;
    logic [3:0]       run_nxt;
    logic             lock_nxt;
    logic             cnt_expired;

    // Rising edge of the monitored signal; sig_q clears on reset so a high
    // input in the first cycle afterwards counts as an edge.
    assign rise        = bus.sig_in & ~sig_q;
    assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT));

    // Decode the running count into a select code; lowest code wins if
    // several divider periods happen to coincide.
    always_comb begin
        hit  = 1'b1;
        code = 2'd0;
        if (cnt_q == CNT_W'(DIV0)) begin
            code = 2'd0;
        end else if (cnt_q == CNT_W'(DIV1)) begin
            code = 2'd1;
        end else if (cnt_q == CNT_W'(DIV2)) begin
            code = 2'd2;
        end else if (cnt_q == CNT_W'(DIV3)) begin
            code = 2'd3;
        end else begin
            hit = 1'b0;
        end
    end

    // Length of the run of identical codes after the measurement completing
    // now; a run of zero means the previous measurement missed or timed out.
    always_comb begin
        run_nxt = 4'd0;
        if (hit) begin
            if ((code == last_code_q) && (run_q != 4'd0)) begin
                run_nxt = (run_q == RunMax) ? RunMax : run_q + 4'd1;
            end else begin
                run_nxt = 4'd1;
            end
        end
        lock_nxt = hit && (run_nxt >= 4'(LOCK_N));
    end

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sig_q       <= 1'b0;
            cnt_q       <= '0;
            run_q       <= 4'd0;
            last_code_q <= 2'd0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            match_q     <= 1'b0;
            sel_q       <= 2'd0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sig_q     <= bus.sig_in;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // First edge only opens a measurement window.
                    if (rise) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= StMeasure;
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        // An edge on the timeout cycle still closes the period.
                        period_q <= cnt_q;
                        valid_q  <= 1'b1;
                        match_q  <= hit;
                        cnt_q    <= CNT_W'(1);
                        run_q    <= run_nxt;
                        if (hit) begin
                            last_code_q <= code;
                        end
                        // sel_out keeps its old value when lock is lost.
                        if (lock_nxt) begin
                            locked_q <= 1'b1;
                            sel_q    <= code;
                        end else begin
                            locked_q <= 1'b0;
                        end
                    end else if (cnt_expired) begin
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                        run_q     <= 4'd0;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.period  = period_q;
    assign bus.valid   = valid_q;
    assign bus.match   = match_q;
    assign bus.sel_out = sel_q;
    assign bus.locked  = locked_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_div_rate_detector.sv
// Bench for div_rate_detector: a cycle model built on rise timestamps pushes
// the expected valid/timeout events into a queue; a negedge monitor pops and
// compares them against the DUT pulses and tracks the lock status.
module tb_div_rate_detector;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned LOCK_N  = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_rate_detector_if #(.CNT_W(CNT_W)) bus ();

    div_rate_detector #(
        .CNT_W  (CNT_W),
        .DIV0   (2),
        .DIV1   (4),
        .DIV2   (8),
        .DIV3   (16),
        .TIMEOUT(TIMEOUT),
        .LOCK_N (LOCK_N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          is_to;
        int unsigned period;
        bit          match;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;

    // Model state: time stamps of rises and a streak of equal codes.
    int unsigned t = 0;
    bit          m_prev = 1'b0;
    bit          m_armed = 1'b0;
    int unsigned m_last_t = 0;
    int          m_streak = 0;
    int          m_prev_code = 0;
    bit          m_locked = 1'b0;
    int unsigned m_sel = 0;

    function automatic int div_code(input int unsigned p);
        case (p)
            2:       return 0;
            4:       return 1;
            8:       return 2;
            16:      return 3;
            default: return -1;
        endcase
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model, evaluated on the same edges the DUT samples.
    always @(posedge clk) begin
        bit          r;
        int unsigned gap;
        int          c;
        ev_t         e;
        t++;
        if (rst) begin
            m_prev      = 1'b0;
            m_armed     = 1'b0;
            m_streak    = 0;
            m_prev_code = 0;
            m_locked    = 1'b0;
            m_sel       = 0;
        end else begin
            r      = bus.sig_in && !m_prev;
            m_prev = bus.sig_in;
            if (m_armed) begin
                gap = t - m_last_t;
                if (r) begin
                    c = div_code(gap);
                    if (c >= 0) begin
                        if (m_streak > 0 && c == m_prev_code) begin
                            m_streak = (m_streak >= 15) ? 15 : m_streak + 1;
                        end else begin
                            m_streak = 1;
                        end
                        m_prev_code = c;
                        m_locked    = (m_streak >= int'(LOCK_N));
                        if (m_locked) m_sel = c;
                    end else begin
                        m_streak = 0;
                        m_locked = 1'b0;
                    end
                    m_last_t = t;
                    e.is_to  = 1'b0;
                    e.period = gap;
                    e.match  = (c >= 0);
                    exp_q.push_back(e);
                end else if (gap == TIMEOUT) begin
                    m_armed  = 1'b0;
                    m_streak = 0;
                    m_locked = 1'b0;
                    e.is_to  = 1'b1;
                    e.period = 0;
                    e.match  = 1'b0;
                    exp_q.push_back(e);
                end
            end else if (r) begin
                m_armed  = 1'b1;
                m_last_t = t;
            end
        end
    end

    // Monitor: pair DUT pulses with expected events and track lock status.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (bus.valid || bus.timeout) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_pulse: got valid=%0b timeout=%0b, expected none (t=%0t)",
                             bus.valid, bus.timeout, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_is_timeout", 32'(bus.timeout), 32'(e.is_to));
                    chk("pulse_is_valid", 32'(bus.valid), 32'(!e.is_to));
                    if (!e.is_to) begin
                        chk("period", 32'(bus.period), e.period);
                        chk("match", 32'(bus.match), 32'(e.match));
                    end
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_pulse: got none, expected %s (t=%0t)",
                         e.is_to ? "timeout" : "valid", $time);
            end
            chk("locked", 32'(bus.locked), 32'(m_locked));
            chk("sel_out", 32'(bus.sel_out), m_sel);
        end
    end

    task automatic cyc(input bit s, input bit r);
        @(posedge clk);
        #1;
        bus.sig_in = s;
        rst        = r;
    endtask

    task automatic wave(input int p, input int hi, input int n);
        repeat (n) begin
            repeat (hi) cyc(1'b1, 1'b0);
            repeat (p - hi) cyc(1'b0, 1'b0);
        end
    endtask

    // Apply one reset edge, release it, and check every output is cleared.
    task automatic reset_check(input bit s);
        cyc(s, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_period", 32'(bus.period), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_match", 32'(bus.match), 32'd0);
        chk("rst_sel_out", 32'(bus.sel_out), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
    endtask

    initial begin
        int std_p[4];
        int p;
        int k;
        std_p[0] = 2;
        std_p[1] = 4;
        std_p[2] = 8;
        std_p[3] = 16;

        bus.sig_in = 1'b0;
        rst        = 1'b1;
        cyc(1'b0, 1'b1);
        reset_check(1'b0);
        mon_en = 1'b1;

        // Directed sequences.
        wave(8, 4, 4);
        wave(2, 1, 5);
        wave(4, 2, 4);
        wave(16, 8, 3);
        wave(6, 3, 4);
        wave(4, 2, 4);
        repeat (300) cyc(1'b0, 1'b0);
        wave(8, 4, 3);
        wave(4, 2, 4);
        cyc(1'b1, 1'b0);
        reset_check(1'b0);
        wave(4, 2, 4);

        // Randomised mix of divider rates, odd periods, gaps and resets.
        repeat (60) begin
            k = $urandom_range(0, 9);
            if (k <= 5) begin
                p = std_p[$urandom_range(0, 3)];
                wave(p, $urandom_range(1, p - 1), $urandom_range(1, 5));
            end else if (k <= 7) begin
                p = $urandom_range(2, 40);
                wave(p, $urandom_range(1, p - 1), $urandom_range(1, 4));
            end else if (k == 8) begin
                repeat ($urandom_range(200, 300)) cyc(1'b0, 1'b0);
            end else begin
                cyc(1'($urandom_range(0, 1)), 1'b1);
                cyc(1'($urandom_range(0, 1)), 1'b0);
            end
        end

        repeat (5) cyc(1'b0, 1'b0);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
